key_event_encoder: RTL and testbench
====================================

// Module: key_event_encoder
// PURPOSE
//  Converts debounced active-low button levels into discrete key events for the calc core.
//  - One event per press; typematic auto-repeat while the key is held.
//  - Presented on a valid/ready handshake.
//  - Sits between the button debouncer output and the keypad/command decoder.
// PARAMETERS
//  width         5         number of buttons; codeWidth = max(1,$clog2(width)) (localparam)
//  freq          50000000  clock frequency, Hz
//  repeatDelay   500       ms from initial press event to first repeat event
//  repeatPeriod  100       ms between subsequent repeat events
//  Derived: DELAY_TICKS = (freq/1000)*repeatDelay, PERIOD_TICKS = (freq/1000)*repeatPeriod
// PORTS
//  clock      in   1          system clock
//  reset      in   1          async, active-high
//  debounced  in   width      debounced buttons, 0 = pressed, 1 = released
//  evValid    out  1          event available
//  evCode     out  codeWidth  index of button that produced the event
//  evRepeat   out  1          0 = initial press event, 1 = auto-repeat event
//  evReady    in   1          consumer accepts event when evValid & evReady at a clock edge
//  overrun    out  1          one-cycle pulse: an event was dropped because the slot was full
// BEHAVIOUR
//  Reset: evValid=0, evCode=0, evRepeat=0, overrun=0, timer=0, state=IDLE.
//  Reset: previous-level register = all released (all 1s).
//  Press edge: bit i is 1 in prev register and 0 on debounced. prev <= debounced every cycle.
//  Simultaneous press edges: lowest index wins; the others are ignored (no event, no overrun).
//  FSM states: IDLE, DELAY, REPEAT; heldKey register holds the current key.
//  - Any state, press edge on key k:
//    - emit initial event (k, repeat=0); heldKey <= k; timer <= DELAY_TICKS-1; -> DELAY.
//    - latest press wins, even over an already-held key.
//  - DELAY/REPEAT, no press edge, debounced[heldKey]==1 (released): -> IDLE, no event.
//    - Other keys still held do not repeat.
//  - DELAY, timer==0, key held: emit repeat event (heldKey, 1); timer <= PERIOD_TICKS-1; -> REPEAT.
//  - REPEAT, timer==0, key held: emit repeat event; timer <= PERIOD_TICKS-1.
//  - Otherwise the timer decrements by 1 each cycle in DELAY/REPEAT; it is held in IDLE.
//  - Priority in one cycle: press edge > release > timer expiry.
//  Event emission into the single output slot:
//  - Slot free (evValid==0) or draining this edge (evValid & evReady):
//    - load evCode/evRepeat; evValid=1 after that edge.
//  - Slot full and not draining: event dropped, overrun=1 for exactly one cycle.
//    - FSM/timer still advance as if the event was emitted.
//  - evValid & !evReady: evValid, evCode, evRepeat are held stable.
//  - evValid & evReady with no new event: evValid=0 after the edge.
//  Latency: debounced bit low before edge E -> initial event visible after E (1 cycle).
//  - First repeat event loads exactly DELAY_TICKS edges after E.
//  - Each further repeat event loads PERIOD_TICKS edges after the previous one.
//  Reset mid-operation: outputs clear immediately.
//  - A key still held when reset deasserts counts as a new press edge on the first edge after reset.
//  Timer width: $clog2(max(DELAY_TICKS,PERIOD_TICKS)+1) bits, no wrap (reloaded before 0-1).
// TESTING (freq=1000 -> 1 tick/ms; repeatDelay=5, repeatPeriod=2; evReady=1 unless stated)
//  1 Reset, debounced=5'b11111 for 50 cycles -> evValid and overrun never assert; all outputs 0.
//  2 bit2 low before edge 10, held 13 cycles, then released:
//    - evValid after edge 10 only, code 2, repeat=0.
//    - Repeat events (code 2, repeat=1) after edges 15, 17, 19, 21; none after release.
//  3 bits 1 and 3 low on the same edge -> one event, code 1; later repeats carry code 1 only.
//  4 evReady=0; press bit0, 3 cycles later press bit4:
//    - code 0 stays held; overrun pulses exactly 1 cycle.
//    - Raise evReady -> code 0 accepted.
//    - Later repeat events carry code 4.
//  5 Press bit3 at edge 10, release before edge 15 -> only the initial event; no repeat event ever.
//  6 Assert reset while in REPEAT with evValid=1:
//    - evValid=0 immediately.
//    - Release reset with bit2 still low -> initial event code 2, repeat=0, after the first edge.

Source files
------------

// File: rtl/key_event_encoder.sv
// Turns debounced active-low button levels into press / typematic-repeat key
// events, delivered through a single-entry valid/ready output slot.
module key_event_encoder #(
    parameter int width        = 5,
    parameter int freq         = 50000000,
    parameter int repeatDelay  = 500,
    parameter int repeatPeriod = 100,
    localparam int codeWidth   = (width > 1) ? $clog2(width) : 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [width-1:0]     debounced_i,
    output logic                 ev_valid_o,
    output logic [codeWidth-1:0] ev_code_o,
    output logic                 ev_repeat_o,
    input  logic                 ev_ready_i,
    output logic                 overrun_o,
    output logic [1:0]           state_o
);

    localparam int DELAY_TICKS  = (freq / 1000) * repeatDelay;
    localparam int PERIOD_TICKS = (freq / 1000) * repeatPeriod;
    localparam int MAX_TICKS    = (DELAY_TICKS > PERIOD_TICKS) ? DELAY_TICKS : PERIOD_TICKS;
    localparam int TW           = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     prev_q;
    logic [codeWidth-1:0] held_q, held_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 valid_q, valid_d;
    logic [codeWidth-1:0] code_q, code_d;
    logic                 rep_q, rep_d;
    logic                 overrun_q, overrun_d;

    logic [width-1:0]     press;
    logic                 press_hit;
    logic [codeWidth-1:0] press_idx;
    logic                 ev_fire;
    logic [codeWidth-1:0] ev_code;
    logic                 ev_rep;

    assign press = prev_q & ~debounced_i;

    // Scan downward so the lowest simultaneous press index is the one kept.
    always_comb begin
        press_hit = 1'b0;
        press_idx = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_hit = 1'b1;
                press_idx = codeWidth'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        timer_d = timer_q;
        ev_fire = 1'b0;
        ev_code = held_q;
        ev_rep  = 1'b0;
        if (press_hit) begin
            ev_fire = 1'b1;
            ev_code = press_idx;
            held_d  = press_idx;
            timer_d = TW'(DELAY_TICKS - 1);
            state_d = DELAY;
        end else if (state_q != IDLE) begin
            if (debounced_i[held_q]) begin
                state_d = IDLE;
            end else if (timer_q == '0) begin
                ev_fire = 1'b1;
                ev_rep  = 1'b1;
                timer_d = TW'(PERIOD_TICKS - 1);
                state_d = REPEAT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    // Handshake: an event transfers on a clock edge where ev_valid_o and
    // ev_ready_i are both high; while valid and not ready the slot is frozen,
    // and an event arriving then is dropped and flagged on overrun_o.
    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        rep_d     = rep_q;
        overrun_d = 1'b0;
        if (ev_fire) begin
            if (!valid_q || ev_ready_i) begin
                valid_d = 1'b1;
                code_d  = ev_code;
                rep_d   = ev_rep;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ev_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            prev_q    <= '1;
            held_q    <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            rep_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= debounced_i;
            held_q    <= held_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            rep_q     <= rep_d;
            overrun_q <= overrun_d;
        end
    end

    assign ev_valid_o  = valid_q;
    assign ev_code_o   = code_q;
    assign ev_repeat_o = rep_q;
    assign overrun_o   = overrun_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder at 1 tick per ms (delay 5, period 2).
module tb_key_event_encoder;

    logic       clock;
    logic       reset;
    logic [4:0] debounced;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_repeat;
    logic       ev_ready;
    logic       overrun;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    key_event_encoder #(
        .width(5), .freq(1000), .repeatDelay(5), .repeatPeriod(2)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .debounced_i(debounced),
        .ev_valid_o (ev_valid),
        .ev_code_o  (ev_code),
        .ev_repeat_o(ev_repeat),
        .ev_ready_i (ev_ready),
        .overrun_o  (overrun),
        .state_o    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_event(input string tag, input logic [2:0] code, input logic rep);
        check({tag, "_valid"}, 32'(ev_valid), 32'(1));
        check({tag, "_code"}, 32'(ev_code), 32'(code));
        check({tag, "_repeat"}, 32'(ev_repeat), 32'(rep));
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            tick();
            check({tag, "_valid"}, 32'(ev_valid), 32'(0));
            check({tag, "_overrun"}, 32'(overrun), 32'(0));
        end
    endtask

    initial begin
        reset     = 1'b1;
        debounced = 5'b11111;
        ev_ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(ev_valid), 32'(0));
        check("rst_code", 32'(ev_code), 32'(0));
        check("rst_repeat", 32'(ev_repeat), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        reset = 1'b0;

        // 1: idle with every button released
        expect_quiet("idle", 50);
        check("idle_code", 32'(ev_code), 32'(0));
        check("idle_repeat", 32'(ev_repeat), 32'(0));

        // 2: bit2 held for 13 edges; repeats at offsets 5,7,9,11
        debounced = 5'b11011;
        tick();
        check_event("t2_press", 3'd2, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 5 || k == 7 || k == 9 || k == 11) begin
                check_event($sformatf("t2_rep%0d", k), 3'd2, 1'b1);
            end else begin
                check($sformatf("t2_gap%0d", k), 32'(ev_valid), 32'(0));
            end
        end
        debounced = 5'b11111;
        expect_quiet("t2_rel", 8);

        // 3: bits 1 and 3 pressed together; lowest index wins
        debounced = 5'b10101;
        tick();
        check_event("t3_press", 3'd1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5 || k == 7) check_event($sformatf("t3_rep%0d", k), 3'd1, 1'b1);
            else check($sformatf("t3_gap%0d", k), 32'(ev_valid), 32'(0));
        end
        debounced = 5'b10111;
        expect_quiet("t3_other_held", 10);
        check("t3_state", 32'(state), 32'(0));
        debounced = 5'b11111;
        expect_quiet("t3_rel", 2);

        // 4: slot blocked, second press overruns
        ev_ready  = 1'b0;
        debounced = 5'b11110;
        tick();
        check_event("t4_press0", 3'd0, 1'b0);
        tick();
        tick();
        check_event("t4_hold2", 3'd0, 1'b0);
        check("t4_no_ovr", 32'(overrun), 32'(0));
        debounced = 5'b01110;
        tick();
        check("t4_ovr", 32'(overrun), 32'(1));
        check_event("t4_hold3", 3'd0, 1'b0);
        tick();
        check("t4_ovr_end", 32'(overrun), 32'(0));
        check_event("t4_hold4", 3'd0, 1'b0);
        ev_ready = 1'b1;
        tick();
        check("t4_drained", 32'(ev_valid), 32'(0));
        tick();
        tick();
        check("t4_gap7", 32'(ev_valid), 32'(0));
        tick();
        check_event("t4_rep4", 3'd4, 1'b1);
        debounced = 5'b11111;
        expect_quiet("t4_rel", 4);

        // 5: release at the edge where the first repeat would fire
        debounced = 5'b10111;
        tick();
        check_event("t5_press", 3'd3, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t5_gap%0d", k), 32'(ev_valid), 32'(0));
        end
        debounced = 5'b11111;
        expect_quiet("t5_rel", 10);

        // 6: reset while in REPEAT with an event pending
        ev_ready  = 1'b0;
        debounced = 5'b11011;
        tick();
        check_event("t6_press", 3'd2, 1'b0);
        for (int k = 1; k <= 5; k++) tick();
        check("t6_ovr", 32'(overrun), 32'(1));
        check("t6_state_rep", 32'(state), 32'(2));
        check_event("t6_pending", 3'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(ev_valid), 32'(0));
        check("t6_async_ovr", 32'(overrun), 32'(0));
        check("t6_async_state", 32'(state), 32'(0));
        tick();
        reset = 1'b0;
        check("t6_rst_valid", 32'(ev_valid), 32'(0));
        tick();
        check_event("t6_after_rst", 3'd2, 1'b0);
        check("t6_state_delay", 32'(state), 32'(1));
        ev_ready  = 1'b1;
        debounced = 5'b11111;
        tick();
        check("t6_accept", 32'(ev_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
